// File: rtl/lfsr_rand_server_pkg.sv
// Shared types and constants for the LFSR random-number server.
// Holds the FSM state type and the maximal-length Galois tap table.
package lfsr_rand_server_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_WARM  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_GRANT = 3'd3,
        ST_STEP  = 3'd4
    } state_t;

    // Right-shifting Galois taps giving a maximal-length sequence for common lengths.
    function automatic logic [31:0] max_len_taps(input int len);
        case (len)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            32:      return 32'hA300_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lfsr_rand_server_lfsr.sv
// Right-shifting Galois LFSR with synchronous seed load and step enable.
// A zero seed is replaced by all-ones so the register never locks up.
module lfsr_rand_server_lfsr #(
    parameter int             LEN   = 16,
    parameter logic [LEN-1:0] TAPS  = 16'hB400,
    parameter int             OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [LEN-1:0]   seed,
    output logic [OUT_W-1:0] word
);

    logic [LEN-1:0] r_sreg;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= (seed == '0) ? '1 : seed;
        end else if (en) begin
            r_sreg <= r_sreg[0] ? ((r_sreg >> 1) ^ TAPS) : (r_sreg >> 1);
        end
    end

    assign word = r_sreg[OUT_W-1:0];

endmodule

// File: rtl/lfsr_rand_server.sv
// Round-robin random-number server: sequences one shared Galois LFSR through
// seed load, warm-up, one word per grant, then decorrelation steps.
module lfsr_rand_server
    import lfsr_rand_server_pkg::*;
#(
    parameter int             N     = 4,
    parameter int             LEN   = 16,
    parameter logic [LEN-1:0] TAPS  = LEN'(max_len_taps(LEN)),
    parameter int             OUT_W = 8,
    parameter int             STEPS = 8,
    parameter int             WARM  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN-1:0]   seed,
    input  logic             reseed,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [OUT_W-1:0] rdata,
    output logic             ready
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(max_int(STEPS, WARM) + 1);

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_rr_ptr;
    logic [PW-1:0]    w_pick;
    logic [LEN-1:0]   r_seed_q;
    logic             r_pend;
    logic [N-1:0]     r_gnt;
    logic [OUT_W-1:0] r_rdata;
    logic             r_ready;
    logic [OUT_W-1:0] w_word;
    logic             w_lfsr_rst;
    logic             w_lfsr_en;

    // Same result as scanning {req,req} rotated by ptr: lowest hit at or above ptr wins.
    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] ptr);
        logic [PW-1:0] pick;
        pick = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (r[PW'((int'(ptr) + k) % N)]) pick = PW'((int'(ptr) + k) % N);
        end
        return pick;
    endfunction

    assign w_pick     = rr_pick(req, r_rr_ptr);
    assign w_lfsr_rst = rst | (r_state == ST_INIT);
    assign w_lfsr_en  = (r_state == ST_WARM) | (r_state == ST_STEP);

    lfsr_rand_server_lfsr #(
        .LEN   (LEN),
        .TAPS  (TAPS),
        .OUT_W (OUT_W)
    ) u_lfsr (
        .clk  (clk),
        .rst  (w_lfsr_rst),
        .en   (w_lfsr_en),
        .seed (r_seed_q),
        .word (w_word)
    );

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:  w_next = (WARM == 0) ? ST_IDLE : ST_WARM;
            ST_WARM:  if (r_cnt == CW'(WARM - 1)) w_next = ST_IDLE;
            ST_IDLE: begin
                if (r_pend || reseed) w_next = ST_INIT;
                else if (|req)        w_next = ST_GRANT;
            end
            ST_GRANT: w_next = ST_STEP;
            ST_STEP:  if (r_cnt == CW'(STEPS - 1)) w_next = ST_IDLE;
            default:  w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_INIT;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
            r_seed_q <= seed;
            r_pend   <= 1'b0;
            r_gnt    <= '0;
            r_rdata  <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_lfsr_en && (w_next == r_state)) ? r_cnt + CW'(1) : '0;
            r_ready <= (w_next == ST_IDLE);
            r_gnt   <= '0;

            if (reseed) r_seed_q <= seed;
            // A reseed seen in IDLE is consumed immediately by the jump to INIT.
            if ((r_state == ST_IDLE) && (r_pend || reseed)) r_pend <= 1'b0;
            else if (reseed)                                 r_pend <= 1'b1;

            if (w_next == ST_GRANT) begin
                r_gnt    <= N'(1) << w_pick;
                r_rdata  <= w_word;
                r_rr_ptr <= PW'((int'(w_pick) + 1) % N);
            end
        end
    end

    assign gnt   = r_gnt;
    assign rdata = r_rdata;
    assign ready = r_ready;

endmodule

// File: tb/tb_lfsr_rand_server.sv
// Self-checking bench for lfsr_rand_server: table-driven first/second grants,
// hand-written corner sequences, and a randomized run against a transaction model.
module tb_lfsr_rand_server;

    localparam int             N     = 4;
    localparam int             LEN   = 16;
    localparam int             OUT_W = 8;
    localparam int             STEPS = 3;
    localparam int             WARM  = 4;
    localparam logic [LEN-1:0] TAPS  = 16'hB400;

    logic             clk = 1'b0;
    logic             rst;
    logic [LEN-1:0]   seed;
    logic             reseed;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [OUT_W-1:0] rdata;
    logic             ready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lfsr_rand_server #(
        .N(N), .LEN(LEN), .TAPS(TAPS), .OUT_W(OUT_W), .STEPS(STEPS), .WARM(WARM)
    ) dut (
        .clk(clk), .rst(rst), .seed(seed), .reseed(reseed),
        .req(req), .gnt(gnt), .rdata(rdata), .ready(ready)
    );

    typedef struct {
        logic [15:0] seed;
        logic [3:0]  req;
        logic [3:0]  g1;
        logic [7:0]  d1;
        logic [3:0]  g2;
        logic [7:0]  d2;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    endtask

    // Reference LFSR: divide-by-polynomial stepping of the Galois register.
    function automatic logic [15:0] advance(input logic [15:0] s, input int k);
        logic [15:0] v;
        v = s;
        for (int i = 0; i < k; i++) v = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
        return v;
    endfunction

    function automatic logic [15:0] fresh(input logic [15:0] sd);
        return advance((sd == 16'h0) ? 16'hFFFF : sd, WARM);
    endfunction

    function automatic int model_pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[2'((ptr + k) % N)]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic [15:0] sd);
        rst = 1'b1; seed = sd; reseed = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int max_cyc, output logic [3:0] g, output logic [7:0] d,
                              output int cyc);
        g = '0; d = '0; cyc = 0;
        while (cyc < max_cyc) begin
            step();
            cyc++;
            if (gnt != '0) begin
                g = gnt; d = rdata;
                return;
            end
        end
        check("grant_timeout", 32'(gnt != '0), 32'd1);
    endtask

    logic [3:0]  g;
    logic [7:0]  d;
    int          cyc;
    logic [3:0]  exp_seq[5];
    logic [15:0] m_sreg, last_seed;
    logic        m_pend;
    int          m_ptr, w, n_grants;
    logic [3:0]  sampled;

    initial begin
        vecs[0] = '{16'h0001, 4'b0001, 4'b0001, 8'h80, 4'b0001, 8'hD0};
        vecs[1] = '{16'h0000, 4'b0001, 4'b0001, 8'h7F, 4'b0001, 8'h4F};
        vecs[2] = '{16'h0001, 4'b1000, 4'b1000, 8'h80, 4'b1000, 8'hD0};
        vecs[3] = '{16'h0000, 4'b0110, 4'b0010, 8'h7F, 4'b0100, 8'h4F};
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset values and warm-up length before ready.
        req = '0;
        apply_reset(16'h0001);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        for (int i = 1; i <= WARM + 1; i++) begin
            step();
            check("ready_after_warm", 32'(ready), 32'(i == WARM + 1));
        end

        // First two grants after reset for several seeds and request patterns.
        for (int v = 0; v < 4; v++) begin
            req = vecs[v].req;
            apply_reset(vecs[v].seed);
            wait_grant(40, g, d, cyc);
            check("tbl_first_latency", 32'(cyc), 32'(WARM + 2));
            check("tbl_g1", 32'(g), 32'(vecs[v].g1));
            check("tbl_d1", 32'(d), 32'(vecs[v].d1));
            wait_grant(40, g, d, cyc);
            check("tbl_spacing", 32'(cyc), 32'(STEPS + 2));
            check("tbl_g2", 32'(g), 32'(vecs[v].g2));
            check("tbl_d2", 32'(d), 32'(vecs[v].d2));
        end

        // All four requesting: strict rotation, one grant every STEPS+2 cycles.
        req = 4'b1111;
        apply_reset(16'h0001);
        for (int i = 0; i < 5; i++) begin
            wait_grant(40, g, d, cyc);
            check("rr4_gnt", 32'(g), 32'(exp_seq[i]));
            if (i > 0) check("rr4_spacing", 32'(cyc), 32'(STEPS + 2));
        end

        // Pointer at 2 with req 0101: requester 2 first, then requester 0.
        req = 4'b0010;
        apply_reset(16'h0001);
        wait_grant(40, g, d, cyc);
        check("rr_ptr_setup", 32'(g), 32'b0010);
        req = 4'b0101;
        wait_grant(40, g, d, cyc);
        check("rr_wrap_first", 32'(g), 32'b0100);
        req = req & ~g;
        wait_grant(40, g, d, cyc);
        check("rr_wrap_second", 32'(g), 32'b0001);

        // Reseed during STEP: step finishes, then re-init and warm-up from the new seed.
        req = 4'b0001;
        apply_reset(16'h0000);
        wait_grant(40, g, d, cyc);
        check("reseed_pre_word", 32'(d), 32'h7F);
        step();
        reseed = 1'b1; seed = 16'h0001;
        step();
        reseed = 1'b0;
        wait_grant(40, g, d, cyc);
        check("reseed_latency", 32'(cyc), 32'(WARM + 5));
        check("reseed_word", 32'(d), 32'h80);

        // Reset during GRANT drops the grant and restarts the power-on sequence.
        req = 4'b0001;
        apply_reset(16'h0001);
        wait_grant(40, g, d, cyc);
        rst = 1'b1;
        step();
        check("rst_grant_gnt", 32'(gnt), 32'd0);
        check("rst_grant_rdata", 32'(rdata), 32'd0);
        check("rst_grant_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        wait_grant(40, g, d, cyc);
        check("rst_restart_latency", 32'(cyc), 32'(WARM + 2));
        check("rst_restart_word", 32'(d), 32'h80);

        // Randomized traffic with occasional reseeds against a transaction-level model.
        req = '0;
        last_seed = 16'($urandom);
        apply_reset(last_seed);
        m_pend = 1'b1; m_ptr = 0; m_sreg = '0; n_grants = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            sampled = req;
            if (gnt != '0) begin
                if (m_pend) begin
                    m_sreg = fresh(last_seed);
                    m_pend = 1'b0;
                end
                w = model_pick(sampled, m_ptr);
                check("rand_gnt", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
                check("rand_rdata", 32'(rdata), 32'(m_sreg[7:0]));
                if (w >= 0) m_ptr = (w + 1) % N;
                m_sreg = advance(m_sreg, STEPS);
                n_grants++;
                req = req & ~gnt;
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom_range(0, 3) == 0)) req[i] = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) begin
                reseed = 1'b1;
                seed = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                last_seed = seed;
                m_pend = 1'b1;
            end else begin
                reseed = 1'b0;
            end
        end
        check("rand_progress", 32'(n_grants > 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
